// File: rtl/ans_pkg.sv
// Shared constants and state encoding for the ANS decoder table loader.
// The loader and its cumulative-sum accumulator both take their widths from here.
package ans_pkg;

    localparam int SYM_WIDTH   = 4;
    localparam int CNT_WIDTH   = 8;
    localparam int SYM_COUNT   = 16;
    localparam int CUM_WIDTH   = CNT_WIDTH + SYM_WIDTH;
    localparam int NIB_PER_SYM = CNT_WIDTH / 4;
    localparam int NIB_IDX_W   = (NIB_PER_SYM > 1) ? $clog2(NIB_PER_SYM) : 1;

    typedef logic [1:0] loader_state_t;

    localparam loader_state_t ST_IDLE  = 2'd0;
    localparam loader_state_t ST_LOAD  = 2'd1;
    localparam loader_state_t ST_ACCUM = 2'd2;
    localparam loader_state_t ST_READY = 2'd3;

endpackage

// File: rtl/ans_cdf_accumulator.sv
// Serial inclusive prefix-sum engine: one symbol per enabled cycle while step_i is high.
// Index and running sum return to zero whenever it is idle, so each pass starts clean.
module ans_cdf_accumulator
    import ans_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           ena_i,
    input  logic                           step_i,
    input  logic [SYM_COUNT*CNT_WIDTH-1:0] counts_i,
    output logic [SYM_COUNT*CUM_WIDTH-1:0] cum_o,
    output logic                           last_o,
    output logic [CUM_WIDTH-1:0]           sum_next_o
);

    logic [SYM_WIDTH-1:0]                  acc_idx_q;
    logic [CUM_WIDTH-1:0]                  sum_q;
    logic [SYM_COUNT-1:0][CUM_WIDTH-1:0]   cum_q;
    logic [CNT_WIDTH-1:0]                  cur_count;

    assign cur_count  = counts_i[acc_idx_q*CNT_WIDTH +: CNT_WIDTH];
    assign sum_next_o = sum_q + CUM_WIDTH'(cur_count);
    assign last_o     = (acc_idx_q == SYM_WIDTH'(SYM_COUNT - 1));
    assign cum_o      = cum_q;

    // cum[] is only written while stepping, so it holds steady once the table is ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_idx_q <= '0;
            sum_q     <= '0;
            cum_q     <= '0;
        end else if (ena_i) begin
            if (step_i) begin
                cum_q[acc_idx_q] <= sum_next_o;
                sum_q            <= sum_next_o;
                acc_idx_q        <= acc_idx_q + 1'b1;
            end else begin
                acc_idx_q <= '0;
                sum_q     <= '0;
            end
        end
    end

endmodule

// File: rtl/ans_table_loader.sv
// Loads the ANS symbol frequency table from a nibble stream, builds the cumulative table,
// and holds the decoder disabled until a complete, non-empty table is in place.
module ans_table_loader
    import ans_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           cfg_start,
    input  logic [SYM_WIDTH-1:0]           in,
    input  logic                           in_vld,
    output logic                           in_rdy,
    output logic [SYM_COUNT*CNT_WIDTH-1:0] counts_unpacked,
    output logic [SYM_COUNT*CUM_WIDTH-1:0] cumulative_unpacked,
    output logic                           table_vld,
    output logic                           dec_ena,
    output logic                           err
);

    loader_state_t                        state_q, state_d;
    logic [SYM_WIDTH-1:0]                 sym_idx_q, sym_idx_d;
    logic [NIB_IDX_W-1:0]                 nib_idx_q, nib_idx_d;
    logic                                 err_q, err_d;
    logic [SYM_COUNT-1:0][CNT_WIDTH-1:0]  counts_q;

    logic                                 xfer;
    logic                                 nib_last;
    logic                                 sym_last;
    logic                                 acc_last;
    logic [CUM_WIDTH-1:0]                 acc_sum_next;

    assign in_rdy    = (state_q == ST_LOAD) && ena;
    assign xfer      = in_vld && in_rdy;
    assign nib_last  = (nib_idx_q == NIB_IDX_W'(NIB_PER_SYM - 1));
    assign sym_last  = (sym_idx_q == SYM_WIDTH'(SYM_COUNT - 1));
    assign table_vld = (state_q == ST_READY);
    assign dec_ena   = ena && table_vld;
    assign err       = err_q;
    assign counts_unpacked = counts_q;

    ans_cdf_accumulator u_accum (
        .clk_i      (clk),
        .rst_i      (rst),
        .ena_i      (ena),
        .step_i     (state_q == ST_ACCUM),
        .counts_i   (counts_q),
        .cum_o      (cumulative_unpacked),
        .last_o     (acc_last),
        .sum_next_o (acc_sum_next)
    );

    // cfg_start is only honoured outside LOAD/ACCUM so a half-built table is never restarted.
    always_comb begin
        state_d   = state_q;
        sym_idx_d = sym_idx_q;
        nib_idx_d = nib_idx_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (cfg_start) begin
                    state_d   = ST_LOAD;
                    err_d     = 1'b0;
                    sym_idx_d = '0;
                    nib_idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (nib_last) begin
                        nib_idx_d = '0;
                        if (sym_last) begin
                            state_d = ST_ACCUM;
                        end else begin
                            sym_idx_d = sym_idx_q + 1'b1;
                        end
                    end else begin
                        nib_idx_d = nib_idx_q + 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (acc_last) begin
                    if (acc_sum_next == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Everything freezes while ena is low; xfer already implies ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sym_idx_q <= '0;
            nib_idx_q <= '0;
            err_q     <= 1'b0;
            counts_q  <= '0;
        end else if (ena) begin
            state_q   <= state_d;
            sym_idx_q <= sym_idx_d;
            nib_idx_q <= nib_idx_d;
            err_q     <= err_d;
            if (xfer) begin
                counts_q[sym_idx_q][nib_idx_q*SYM_WIDTH +: SYM_WIDTH] <= in;
            end
        end
    end

endmodule

// File: tb/tb_ans_table_loader.sv
// Scoreboard bench for ans_table_loader: each load pushes its modelled tables,
// which are popped and compared when the loader reports a finished table or an error.
module tb_ans_table_loader;
    import ans_pkg::*;

    localparam int NIBS = SYM_COUNT * NIB_PER_SYM;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           ena;
    logic                           cfg_start;
    logic [SYM_WIDTH-1:0]           in_nib;
    logic                           in_vld;
    logic                           in_rdy;
    logic [SYM_COUNT*CNT_WIDTH-1:0] counts_unpacked;
    logic [SYM_COUNT*CUM_WIDTH-1:0] cumulative_unpacked;
    logic                           table_vld;
    logic                           dec_ena;
    logic                           err;

    typedef struct {
        logic [SYM_COUNT*CNT_WIDTH-1:0] counts;
        logic [SYM_COUNT*CUM_WIDTH-1:0] cum;
        logic                           err;
        int                             latency;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cycle  = 0;

    logic [NIBS*4-1:0] uniTable, maxTable, zeroTable, reloadTable, rndTable;

    ans_table_loader dut (
        .clk                 (clk),
        .rst                 (rst),
        .ena                 (ena),
        .cfg_start           (cfg_start),
        .in                  (in_nib),
        .in_vld              (in_vld),
        .in_rdy              (in_rdy),
        .counts_unpacked     (counts_unpacked),
        .cumulative_unpacked (cumulative_unpacked),
        .table_vld           (table_vld),
        .dec_ena             (dec_ena),
        .err                 (err)
    );

    // 10 ns clock; the bench drives and samples on the falling edge.
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic checkResetState();
        checkOutput("rstCounts", counts_unpacked, '0);
        checkOutput("rstCum", cumulative_unpacked, '0);
        checkOutput("rstTableVld", table_vld, 0);
        checkOutput("rstDecEna", dec_ena, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstInRdy", in_rdy, 0);
    endtask

    task automatic startLoad();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Presents one nibble and returns on the falling edge after the edge that accepted it.
    task automatic sendNibble(input logic [3:0] nib, input bit gaps, input bit pulseCfg);
        int budget = 0;
        if (gaps) begin
            in_vld = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_nib    = nib;
        in_vld    = 1'b1;
        cfg_start = pulseCfg;
        #1;
        while (!in_rdy && budget < 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (budget >= 50) checkOutput("rdyTimeout", 0, 1);
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [NIBS*4-1:0] nibs, input bit gaps, input int cfgAt, input int enaDrop);
        exp_t e;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CUM_WIDTH-1:0] sum = '0;
        for (int j = 0; j < SYM_COUNT; j++) begin
            for (int k = 0; k < NIB_PER_SYM; k++)
                cnt[k*4 +: 4] = nibs[(j*NIB_PER_SYM + k)*4 +: 4];
            e.counts[j*CNT_WIDTH +: CNT_WIDTH] = cnt;
            sum = sum + CUM_WIDTH'(cnt);
            e.cum[j*CUM_WIDTH +: CUM_WIDTH] = sum;
        end
        e.err     = (sum == '0);
        e.latency = SYM_COUNT + enaDrop;
        sb.push_back(e);
        for (int i = 0; i < NIBS; i++)
            sendNibble(nibs[i*4 +: 4], gaps, (i == cfgAt));
        in_vld = 1'b0;
    endtask

    task automatic awaitTable(input int enaDrop);
        exp_t e;
        int start  = cycle;
        int budget = 0;
        while (!(table_vld || err) && budget < 200) begin
            if (enaDrop > 0 && budget == 3) ena = 1'b0;
            if (enaDrop > 0 && budget == 3 + enaDrop) ena = 1'b1;
            @(negedge clk);
            budget++;
        end
        ena = 1'b1;
        #1;
        if (budget >= 200) checkOutput("tableTimeout", 0, 1);
        if (sb.size() == 0) begin
            checkOutput("sbEmpty", 0, 1);
            return;
        end
        e = sb.pop_front();
        checkOutput("latency", cycle - start, e.latency);
        checkOutput("counts", counts_unpacked, e.counts);
        checkOutput("cum", cumulative_unpacked, e.cum);
        checkOutput("err", err, e.err);
        checkOutput("tableVld", table_vld, !e.err);
        checkOutput("decEna", dec_ena, !e.err);
        checkOutput("inRdyDone", in_rdy, 0);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; cfg_start = 1'b0; in_vld = 1'b0; in_nib = '0;
        for (int j = 0; j < NIBS; j++) begin
            uniTable[j*4 +: 4]    = (j % 2 == 0) ? 4'd1 : 4'd0;
            maxTable[j*4 +: 4]    = 4'hF;
            zeroTable[j*4 +: 4]   = 4'd0;
            reloadTable[j*4 +: 4] = (j % 2 != 0) ? 4'd0 : ((j == 0) ? 4'd2 : 4'd1);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checkResetState();
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] uniform table");
        startLoad();
        applyStimulus(uniTable, 1'b0, -1, 0);
        awaitTable(0);
        checkOutput("uniCum0", cumulative_unpacked[0 +: CUM_WIDTH], 1);
        checkOutput("uniCum15", cumulative_unpacked[15*CUM_WIDTH +: CUM_WIDTH], 16);
        ena = 1'b0;
        #1;
        checkOutput("decEnaOff", dec_ena, 0);
        checkOutput("tableVldHeld", table_vld, 1);
        @(negedge clk);
        ena = 1'b1;
        #1;
        checkOutput("decEnaOn", dec_ena, 1);
        @(negedge clk);

        $display("[TB] max counts, back to back then with gaps");
        startLoad();
        applyStimulus(maxTable, 1'b0, -1, 0);
        awaitTable(0);
        checkOutput("maxCum0", cumulative_unpacked[0 +: CUM_WIDTH], 255);
        checkOutput("maxCum15", cumulative_unpacked[15*CUM_WIDTH +: CUM_WIDTH], 4080);
        startLoad();
        applyStimulus(maxTable, 1'b1, -1, 0);
        awaitTable(0);

        $display("[TB] zero table");
        startLoad();
        applyStimulus(zeroTable, 1'b0, -1, 0);
        awaitTable(0);
        @(negedge clk);
        #1;
        checkOutput("zeroIdleRdy", in_rdy, 0);
        checkOutput("zeroIdleVld", table_vld, 0);
        checkOutput("zeroErrSticky", err, 1);
        startLoad();
        #1;
        checkOutput("errCleared", err, 0);
        checkOutput("loadRdy", in_rdy, 1);
        applyStimulus(uniTable, 1'b0, 5, 0);
        awaitTable(0);

        $display("[TB] reload from READY");
        startLoad();
        #1;
        checkOutput("reloadVldDrop", table_vld, 0);
        checkOutput("reloadDecEnaDrop", dec_ena, 0);
        applyStimulus(reloadTable, 1'b1, -1, 0);
        awaitTable(0);
        checkOutput("reloadCum0", cumulative_unpacked[0 +: CUM_WIDTH], 2);
        checkOutput("reloadCum15", cumulative_unpacked[15*CUM_WIDTH +: CUM_WIDTH], 17);

        $display("[TB] reset mid-load");
        startLoad();
        for (int i = 0; i < 10; i++) sendNibble(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        in_vld    = 1'b0;
        rst       = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        #1;
        checkResetState();
        rst       = 1'b0;
        cfg_start = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("postRstIdle", in_rdy, 0);
        for (int j = 0; j < NIBS; j++) rndTable[j*4 +: 4] = 4'($urandom_range(0, 15));
        startLoad();
        applyStimulus(rndTable, 1'b1, -1, 0);
        awaitTable(0);

        $display("[TB] ena dropped during accumulation");
        for (int j = 0; j < NIBS; j++) rndTable[j*4 +: 4] = 4'($urandom_range(0, 15));
        startLoad();
        applyStimulus(rndTable, 1'b0, -1, 5);
        awaitTable(5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ans_table_loader.md
Name: ans_table_loader

Overview:
- Configuration controller for the ANS decoder.
- Accepts a symbol frequency table as a 4-bit nibble stream over a valid/ready handshake, stores the per-symbol counts, and computes the inclusive cumulative table serially.
- Presents both tables in the decoder's flattened bus format, and gates the decoder's enable until a valid table is loaded.
- Supports reload on command.

Parameters:
- SYM_WIDTH, 4, symbol width in bits; input nibble width.
- CNT_WIDTH, 8, per-symbol count width; must be a multiple of 4.
- SYM_COUNT, 16, number of symbols (2**SYM_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock domain; synchronous, active-high
- ena  in  1  global enable; when low, all state is frozen
- cfg_start  in  1  single-cycle pulse: begin loading a table
- in  in  SYM_WIDTH  count nibble
- in_vld  in  1  nibble valid
- in_rdy  out  1  loader ready for a nibble
- counts_unpacked  out  CNT_WIDTH*SYM_COUNT  count[j] at bits j*CNT_WIDTH
- cumulative_unpacked  out  (CNT_WIDTH+SYM_WIDTH)*SYM_COUNT  cum[j] at bits j*(CNT_WIDTH+SYM_WIDTH)
- table_vld  out  1  tables complete and consistent
- dec_ena  out  1  decoder enable; equals ena && table_vld
- err  out  1  last load had total count 0; sticky until next cfg_start

Behaviour:
- Reset: all outputs, including both table buses, read 0 on the next edge; state IDLE; counters 0. A reset mid-LOAD or mid-ACCUM discards the partial table.
- Handshake: standard valid/ready. A transfer occurs on an edge where in_vld && in_rdy are both 1. in_rdy is combinational: (state==LOAD) && ena. in_vld gaps of any length are legal.
- States: IDLE, LOAD, ACCUM, READY.
- IDLE: in_rdy=0, table_vld=0. cfg_start -> LOAD; clears err, sym_idx and nib_idx.
- LOAD:
  - Each transfer writes the nibble into count[sym_idx][nib_idx*4 +: 4]; least-significant nibble first.
  - nib_idx wraps at CNT_WIDTH/4, then sym_idx increments.
  - The transfer of the last nibble of symbol SYM_COUNT-1 -> ACCUM; acc_idx=0, running sum 0.
  - Exactly SYM_COUNT*CNT_WIDTH/4 nibbles are consumed (32 at defaults).
- ACCUM:
  - One symbol per enabled cycle: cum[acc_idx] <= sum + count[acc_idx]; sum updates likewise.
  - After acc_idx=SYM_COUNT-1: if the final sum is 0, set err=1 and go to IDLE; otherwise go to READY.
  - Width CNT_WIDTH+SYM_WIDTH holds the maximum sum (16*255=4080), so no overflow is possible.
- READY: table_vld=1. cfg_start -> LOAD; table_vld=0 and dec_ena=0 from the next cycle.
- Latency: table_vld rises exactly SYM_COUNT enabled edges after the edge accepting the last nibble (16 at defaults).
- cfg_start is ignored in LOAD and ACCUM.
- Simultaneous rst and cfg_start: rst wins.
- ena low: no transfers, no state or counter change, dec_ena=0. Resumes exactly where it stopped.
- Table buses change only in LOAD/ACCUM, never while table_vld=1.
- The cum[j] convention is inclusive prefix sums: cum[SYM_COUNT-1] is the total, and symbol j covers slots [cum[j-1], cum[j]).

Decomposition:
- Shared package ans_pkg: SYM_WIDTH, CNT_WIDTH, SYM_COUNT, the derived CUM_WIDTH, and the loader state enum typedef.
- Optional sub-module ans_cdf_accumulator: holds acc_idx and the running sum and writes cum[]. The FSM and handshake stay in ans_table_loader.

Test Plan:
- Uniform table: after reset, pulse cfg_start, send 32 nibbles (1,0 repeated) with in_vld held high -> table_vld high 16 cycles after the last accept; cum[j]=j+1 for all j; count[j]=1; dec_ena tracks ena.
- Max counts: all nibbles F -> count[j]=255, cum[15]=4080, cum[0]=255, no overflow; then randomized in_vld gaps give an identical result.
- Zero table: all nibbles 0 -> err=1, table_vld stays 0, state returns to IDLE, in_rdy=0; a following cfg_start clears err.
- Reload: in READY, pulse cfg_start -> table_vld=0 next cycle; load counts 2,0 for symbol 0 and 1,0 for the rest -> cum[0]=2, cum[15]=17.
- rst asserted after 10 nibbles -> all outputs 0 next edge; new cfg_start plus a full load gives a correct table. Also cfg_start pulsed mid-LOAD is ignored.
- ena dropped for 5 cycles during ACCUM -> table_vld latency extends by exactly 5; table contents are unchanged.
